// File: rtl/alu_pkg.sv
// Shared opcode, state and sizing definitions for the multi-cycle ALU.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_SHIFT
    } state_t;

    // One extra bit so a shift amount equal to WIDTH is representable.
    function automatic int unsigned shamt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Shift-add multiplier datapath: one add-shift step per asserted step_i, low WIDTH bits kept.
module shift_add_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_d_o,
    output logic             last_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_d;

    // acc_d is the accumulator after the current step, so the final product is
    // available in the same cycle as the last step rather than one edge later.
    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    assign acc_d_o = acc_d;
    assign last_o  = (cnt_q == CNT_W'(1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= a_i;
            mplier_q <= b_i;
            cnt_q    <= CNT_W'(WIDTH);
        end else if (step_i && (cnt_q != '0)) begin
            acc_q    <= acc_d;
            mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add ops, shift-add MULT and bit-serial shifts
// behind a START/BUSY/DONE handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = shamt_width(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE
);

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    logic               done_q;
    logic               busy_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   sh_val_q;
    logic [SHAMT_W-1:0] sh_cnt_q;

    logic [SHAMT_W-1:0] shamt_raw;
    logic [SHAMT_W-1:0] shamt_d;
    logic [WIDTH-1:0]   sh_next;
    logic               mul_load;
    logic               mul_last;
    logic [WIDTH-1:0]   mul_prod;

    always_comb begin
        shamt_raw = DATA2[SHAMT_W-1:0];
        shamt_d   = (shamt_raw > SHAMT_W'(WIDTH)) ? SHAMT_W'(WIDTH) : shamt_raw;
        case (op_q)
            OP_SLL:  sh_next = {sh_val_q[WIDTH-2:0], 1'b0};
            OP_SRL:  sh_next = {1'b0, sh_val_q[WIDTH-1:1]};
            default: sh_next = {sh_val_q[WIDTH-1], sh_val_q[WIDTH-1:1]};
        endcase
    end

    assign mul_load = (state_q == ST_IDLE) && START && (SELECT == OP_MUL);

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .CLK     (CLK),
        .RESET   (RESET),
        .load_i  (mul_load),
        .step_i  (state_q == ST_MUL),
        .a_i     (DATA1),
        .b_i     (DATA2),
        .acc_d_o (mul_prod),
        .last_o  (mul_last)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            op_q     <= OP_FWD;
            sh_val_q <= '0;
            sh_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        op_q <= SELECT;
                        case (SELECT)
                            OP_FWD: begin result_q <= DATA2;         done_q <= 1'b1; end
                            OP_ADD: begin result_q <= DATA1 + DATA2; done_q <= 1'b1; end
                            OP_AND: begin result_q <= DATA1 & DATA2; done_q <= 1'b1; end
                            OP_OR:  begin result_q <= DATA1 | DATA2; done_q <= 1'b1; end
                            OP_MUL: begin
                                state_q <= ST_MUL;
                                busy_q  <= 1'b1;
                            end
                            default: begin
                                if (shamt_d == '0) begin
                                    result_q <= DATA1;
                                    done_q   <= 1'b1;
                                end else begin
                                    sh_val_q <= DATA1;
                                    sh_cnt_q <= shamt_d;
                                    state_q  <= ST_SHIFT;
                                    busy_q   <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        result_q <= mul_prod;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    sh_val_q <= sh_next;
                    sh_cnt_q <= sh_cnt_q - SHAMT_W'(1);
                    if (sh_cnt_q == SHAMT_W'(1)) begin
                        result_q <= sh_next;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign RESULT = result_q;
    assign ZERO   = (result_q == '0);
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: the driver queues expected results, the monitor checks each DONE.
module tb_alu_mc;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       START;
    logic [2:0] SELECT;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       BUSY;
    logic       DONE;

    typedef struct {
        logic [7:0]  res;
        int unsigned cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc   = 0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    alu_mc #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .ZERO   (ZERO),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DONE must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (DONE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected DONE", 32'(RESULT), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, " result"}, 32'(RESULT), 32'(e.res));
                chk({e.name, " zero"}, 32'(ZERO), 32'(e.res == 8'h00));
                chk({e.name, " done edge"}, cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_res, input int unsigned lat, input string name);
        exp_t e;
        SELECT = op;
        DATA1  = a;
        DATA2  = b;
        START  = 1'b1;
        e.res  = exp_res;
        e.cyc  = cyc + 1 + lat;
        e.name = name;
        sb.push_back(e);
        @(posedge CLK);
    endtask

    // mode 1: request MULT 2*2 so it is sampled at edge k+2; mode 2: scramble inputs each cycle.
    task automatic wait_done(input int unsigned exp_busy, input int mode, input string name);
        int unsigned busy_n = 0;
        bit          seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            START = 1'b0;
            if (mode == 1 && i == 1) begin
                START  = 1'b1;
                SELECT = OP_MUL;
                DATA1  = 8'd2;
                DATA2  = 8'd2;
            end
            if (mode == 2) begin
                SELECT = 3'($urandom);
                DATA1  = 8'($urandom);
                DATA2  = 8'($urandom);
            end
            if (DONE === 1'b1) seen = 1'b1;
            else if (BUSY === 1'b1) busy_n++;
        end
        chk({name, " done seen"}, 32'(seen), 32'd1);
        chk({name, " busy cycles"}, busy_n, exp_busy);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RESET  = 1'b1;
        START  = 1'b0;
        SELECT = OP_FWD;
        DATA1  = 8'h00;
        DATA2  = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset result", 32'(RESULT), 32'h0);
        chk("reset zero",   32'(ZERO),   32'h1);
        chk("reset busy",   32'(BUSY),   32'h0);
        chk("reset done",   32'(DONE),   32'h0);
        RESET = 1'b0;

        issue(OP_ADD, 8'hFF, 8'h01, 8'h00, 0, "add ff+01");  wait_done(0, 0, "add ff+01");
        @(negedge CLK);
        issue(OP_MUL, 8'd13, 8'd11, 8'h8F, 8, "mul 13*11");  wait_done(8, 0, "mul 13*11");
        issue(OP_MUL, 8'd200, 8'd3, 8'h58, 8, "mul 200*3");  wait_done(8, 0, "mul 200*3");
        issue(OP_SLL, 8'h81, 8'd3, 8'h08, 3, "sll 81<<3");   wait_done(3, 0, "sll 81<<3");
        issue(OP_SRA, 8'h90, 8'd9, 8'hFF, 8, "sra 90>>9");   wait_done(8, 0, "sra 90>>9");
        issue(OP_SRL, 8'h5A, 8'd0, 8'h5A, 0, "srl 5a>>0");   wait_done(0, 0, "srl 5a>>0");
        issue(OP_FWD, 8'h12, 8'h34, 8'h34, 0, "fwd");        wait_done(0, 0, "fwd");
        issue(OP_AND, 8'hF0, 8'h3C, 8'h30, 0, "and");        wait_done(0, 0, "and");
        issue(OP_OR,  8'hF0, 8'h0F, 8'hFF, 0, "or");         wait_done(0, 0, "or");

        issue(OP_MUL, 8'd5, 8'd7, 8'h23, 8, "mul 5*7");      wait_done(8, 1, "mul 5*7");
        // Issued in the DONE cycle of the previous op.
        issue(OP_ADD, 8'd3, 8'd4, 8'h07, 0, "add b2b");      wait_done(0, 0, "add b2b");

        @(negedge CLK);
        issue(OP_MUL, 8'd9, 8'd9, 8'h51, 8, "mul abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            START = 1'b0;
        end
        void'(sb.pop_back());
        RESET = 1'b1;
        @(negedge CLK);
        chk("abort result", 32'(RESULT), 32'h0);
        chk("abort busy",   32'(BUSY),   32'h0);
        chk("abort zero",   32'(ZERO),   32'h1);
        chk("abort done",   32'(DONE),   32'h0);
        RESET = 1'b0;
        repeat (10) @(negedge CLK);
        chk("post abort busy", 32'(BUSY), 32'h0);

        issue(OP_MUL, 8'd15, 8'd17, 8'hFF, 8, "mul 15*17");  wait_done(8, 0, "mul 15*17");
        issue(OP_SRL, 8'hF0, 8'd5, 8'h07, 5, "srl f0>>5");   wait_done(5, 2, "srl f0>>5");
        START = 1'b0;
        issue(OP_SLL, 8'h01, 8'h0F, 8'h00, 8, "sll clamp");  wait_done(8, 0, "sll clamp");
        START = 1'b0;

        repeat (5) @(negedge CLK);
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
